// File: rtl/cp0_timer_irq.sv
// MIPS-style coprocessor 0: BadVAddr, Count/Compare timer, Status, Cause, EPC.
// Exception commit beats eret, which beats mtc0, register by register.
module cp0_timer_irq #(
  parameter int          NUM_HW_INT   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mfc0,
  input  logic                  mtc0,
  input  logic [4:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic                  exception,
  input  logic [4:0]            exc_code,
  input  logic                  bd,
  input  logic [31:0]           pc,
  input  logic                  bad_we,
  input  logic [31:0]           bad_addr,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           status,
  output logic [31:0]           epc_out,
  output logic                  int_req,
  output logic                  timer_int
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [3:0] PRE_MAX    = 4'(COUNT_DIV - 1);

  // Status fields
  logic                  ie_q, ie_d;
  logic                  exl_q, exl_d;
  logic [7:0]            im_q, im_d;
  // Cause fields
  logic                  bd_q, bd_d;
  logic                  ti_q, ti_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [4:0]            exc_q, exc_d;
  // Remaining registers
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           badv_q, badv_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [3:0]            pre_q, pre_d;
  logic                  inc_q, inc_d;
  logic [NUM_HW_INT-1:0] hw_q;

  logic                  wr_badv, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [7:0]            ip;
  logic [31:0]           cause;

  assign wr_badv    = mtc0 && (addr == A_BADVADDR);
  assign wr_count   = mtc0 && (addr == A_COUNT);
  assign wr_compare = mtc0 && (addr == A_COMPARE);
  assign wr_status  = mtc0 && (addr == A_STATUS);
  assign wr_cause   = mtc0 && (addr == A_CAUSE);
  assign wr_epc     = mtc0 && (addr == A_EPC);

  // Line i lands on IP[2+i]; the timer shares IP[7] with the top line.
  always_comb begin
    ip = '0;
    ip[1:0] = ip_sw_q;
    for (int i = 0; i < NUM_HW_INT; i++) begin
      ip[2+i] = hw_q[i];
    end
    ip[7] = ip[7] | ti_q;
  end

  assign cause     = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_q, 2'b00};
  assign status    = {16'b0, im_q, 6'b0, exl_q, ie_q};
  assign epc_out   = epc_q;
  assign timer_int = ti_q;
  assign int_req   = ie_q & ~exl_q & (|(ip & im_q));

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (addr)
        A_BADVADDR: rdata = badv_q;
        A_COUNT:    rdata = count_q;
        A_COMPARE:  rdata = compare_q;
        A_STATUS:   rdata = status;
        A_CAUSE:    rdata = cause;
        A_EPC:      rdata = epc_q;
        default:    rdata = '0;
      endcase
    end
  end

  always_comb begin
    ie_d    = ie_q;
    exl_d   = exl_q;
    im_d    = im_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    ip_sw_d = ip_sw_q;
    epc_d   = epc_q;
    badv_d  = badv_q;

    if (exception) begin
      exl_d = 1'b1;
      exc_d = exc_code;
      bd_d  = bd;
      if (!exl_q) begin
        epc_d = bd ? (pc - 32'd4) : pc;
      end
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (wr_status) begin
      ie_d  = wdata[0];
      exl_d = wdata[1];
      im_d  = wdata[15:8];
    end

    if (wr_cause && !exception) begin
      ip_sw_d = wdata[9:8];
    end
    if (wr_epc && !exception) begin
      epc_d = wdata;
    end
    if (exception && bad_we) begin
      badv_d = bad_addr;
    end else if (wr_badv) begin
      badv_d = wdata;
    end
  end

  // Timer: a match is flagged on the edge after Count steps onto Compare;
  // a Compare write always clears TI, even against a simultaneous match.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    pre_d     = pre_q;
    inc_d     = 1'b0;
    ti_d      = ti_q;

    if (inc_q && (count_q == compare_q)) begin
      ti_d = 1'b1;
    end
    if (wr_compare) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end

    if (wr_count) begin
      count_d = wdata;
      pre_d   = '0;
    end else if (pre_q == PRE_MAX) begin
      pre_d   = '0;
      count_d = count_q + 32'd1;
      inc_d   = 1'b1;
    end else begin
      pre_d = pre_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q      <= RESET_STATUS[0];
      exl_q     <= RESET_STATUS[1];
      im_q      <= RESET_STATUS[15:8];
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      ip_sw_q   <= '0;
      exc_q     <= '0;
      epc_q     <= '0;
      badv_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      pre_q     <= '0;
      inc_q     <= 1'b0;
      hw_q      <= '0;
    end else begin
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      im_q      <= im_d;
      bd_q      <= bd_d;
      ti_q      <= ti_d;
      ip_sw_q   <= ip_sw_d;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pre_q     <= pre_d;
      inc_q     <= inc_d;
      hw_q      <= hw_int;
    end
  end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Bench for cp0_timer_irq: a register-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cp0_timer_irq;

  localparam int NUM_HW_INT = 6;
  localparam int COUNT_DIV  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mfc0, mtc0, exception, eret, bd, bad_we;
  logic [4:0]            addr, exc_code;
  logic [31:0]           wdata, pc, bad_addr;
  logic [NUM_HW_INT-1:0] hw_int;
  logic [31:0]           rdata, status, epc_out;
  logic                  int_req, timer_int;

  int tests_run    = 0;
  int tests_failed = 0;

  cp0_timer_irq #(.NUM_HW_INT(NUM_HW_INT), .COUNT_DIV(COUNT_DIV), .RESET_STATUS(32'h0)) dut (
    .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .addr(addr), .wdata(wdata),
    .rdata(rdata), .exception(exception), .exc_code(exc_code), .bd(bd), .pc(pc),
    .bad_we(bad_we), .bad_addr(bad_addr), .eret(eret), .hw_int(hw_int),
    .status(status), .epc_out(epc_out), .int_req(int_req), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
  logic [4:0]  m_exc;
  logic        m_bd, m_ti, m_arm;
  logic [1:0]  m_sw;
  logic [5:0]  m_hw;
  int          m_pre;

  function automatic logic [7:0] m_ip();
    return 8'({2'b00, m_hw} << 2) | {m_ti, 7'b0} | {6'b0, m_sw};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // Apply writes lowest priority first; higher-priority commits then overwrite.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_status = 0; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
      m_exc = 0; m_bd = 0; m_ti = 0; m_arm = 0; m_sw = 0; m_hw = 0; m_pre = 0;
    end else begin
      logic [31:0] o_status, o_epc, o_count, o_compare;
      logic [1:0]  o_sw;
      logic        o_arm;
      o_status = m_status; o_epc = m_epc; o_count = m_count;
      o_compare = m_compare; o_sw = m_sw; o_arm = m_arm;

      if (o_arm && o_count == o_compare) m_ti = 1;
      if (mtc0) begin
        case (addr)
          5'd8:  m_badv = wdata;
          5'd11: begin m_compare = wdata; m_ti = 0; end
          5'd12: m_status = wdata & 32'h0000_FF03;
          5'd13: m_sw = wdata[9:8];
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
      if (eret && !exception) m_status = o_status & ~32'h2;
      if (exception) begin
        m_status = o_status | 32'h2;
        m_exc = exc_code;
        m_bd = bd;
        m_sw = o_sw;
        m_epc = o_status[1] ? o_epc : (bd ? pc - 4 : pc);
        if (bad_we) m_badv = bad_addr;
      end

      if (mtc0 && addr == 5'd9) begin
        m_count = wdata; m_pre = 0; m_arm = 0;
      end else if (m_pre == COUNT_DIV - 1) begin
        m_count = o_count + 1; m_pre = 0; m_arm = 1;
      end else begin
        m_pre = m_pre + 1; m_arm = 0;
      end
      m_hw = hw_int;
    end
  end

  always @(negedge clk) begin
    logic exp_int;
    exp_int = m_status[0] & ~m_status[1] & (|(m_ip() & m_status[15:8]));
    check("cmp_status", status, m_status);
    check("cmp_epc", epc_out, m_epc);
    check("cmp_timer_int", {31'b0, timer_int}, {31'b0, m_ti});
    check("cmp_int_req", {31'b0, int_req}, {31'b0, exp_int});
    check("cmp_rdata", rdata, mfc0 ? m_read(addr) : 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    mfc0 = 0; mtc0 = 0; exception = 0; eret = 0; bad_we = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    mfc0 = 1; addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    idle(); mtc0 = 1; addr = a; wdata = v;
    step();
    idle();
  endtask

  initial begin
    logic [31:0] d;
    int cyc_cnt5, cyc_ti, cnt_at_ti;

    rst = 0; idle(); addr = 0; wdata = 0; exc_code = 0; bd = 0; pc = 0;
    bad_addr = 0; hw_int = 0;
    repeat (3) step();
    check("rst_status", status, 32'h0);
    check("rst_epc", epc_out, 32'h0);
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    check("rst_timer_int", {31'b0, timer_int}, 32'h0);
    rd(5'd12, d);
    check("rst_rdata", d, 32'h0);

    step(); idle(); rst = 1;
    rd(5'd9, d); check("count_t0", d, 32'd0);
    step(); rd(5'd9, d); check("count_t1", d, 32'd0);
    step(); rd(5'd9, d); check("count_t2", d, 32'd1);

    step();
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, 32'd5);
    cyc_cnt5 = -1; cyc_ti = -1;
    for (int i = 0; i < 40 && cyc_ti < 0; i++) begin
      rd(5'd9, d);
      if (d == 32'd5 && cyc_cnt5 < 0) cyc_cnt5 = i;
      if (timer_int && cyc_ti < 0) cyc_ti = i;
      step();
    end
    check("timer_seen", {31'b0, cyc_ti >= 0}, 32'd1);
    check("timer_latency", 32'(cyc_ti - cyc_cnt5), 32'd1);
    check("timer_int_req", {31'b0, int_req}, 32'd1);
    wr(5'd11, 32'd100);
    check("timer_clear_ti", {31'b0, timer_int}, 32'd0);
    check("timer_clear_req", {31'b0, int_req}, 32'd0);

    idle(); exception = 1; exc_code = 5'd4; bd = 1; pc = 32'h0040_0010;
    bad_we = 1; bad_addr = 32'h0000_1003;
    step(); idle(); bd = 0;
    check("exc_epc", epc_out, 32'h0040_000C);
    check("exc_status", status, 32'h0000_8003);
    check("exc_int_req", {31'b0, int_req}, 32'd0);
    rd(5'd13, d); check("exc_cause", d, 32'h8000_0010);
    step(); rd(5'd8, d); check("exc_badvaddr", d, 32'h0000_1003);
    step();

    idle(); exception = 1; exc_code = 5'd12; pc = 32'h0040_0100;
    step(); idle();
    check("nest_epc", epc_out, 32'h0040_000C);
    rd(5'd13, d); check("nest_cause", d, 32'h0000_0030);
    step();
    hw_int = 6'b000001;
    wr(5'd12, 32'h0000_0403);
    check("nest_status", status, 32'h0000_0403);
    check("nest_masked", {31'b0, int_req}, 32'd0);
    step();
    eret = 1; step(); idle();
    check("eret_status", status, 32'h0000_0401);
    check("eret_int_req", {31'b0, int_req}, 32'd1);

    exception = 1; exc_code = 5'd0; pc = 32'h0040_0200;
    mtc0 = 1; addr = 5'd12; wdata = 32'h0;
    step(); idle();
    check("prio_mtc0_status", status, 32'h0000_0403);
    check("prio_mtc0_epc", epc_out, 32'h0040_0200);
    eret = 1; step(); idle();
    exception = 1; eret = 1; pc = 32'h0040_0300;
    step(); idle();
    check("prio_eret_status", status, 32'h0000_0403);
    check("prio_eret_epc", epc_out, 32'h0040_0300);
    eret = 1; step(); idle();
    check("prio_eret2_status", status, 32'h0000_0401);

    hw_int = 0; step();
    check("hw_low_req", {31'b0, int_req}, 32'd0);
    hw_int = 6'b000001; #1;
    check("hw_pre_edge", {31'b0, int_req}, 32'd0);
    step();
    check("hw_post_edge", {31'b0, int_req}, 32'd1);
    wr(5'd12, 32'h0000_0001);
    check("hw_im_masked", {31'b0, int_req}, 32'd0);
    rd(5'd13, d); check("hw_cause_ip2", d, 32'h0000_0400);
    step();
    wr(5'd13, 32'h0000_0300);
    rd(5'd13, d); check("sw_cause_ip", d, 32'h0000_0700);
    step();
    rd(5'd10, d); check("unimpl_read", d, 32'h0);
    step();
    idle(); addr = 5'd13; #1;
    check("no_strobe_read", rdata, 32'h0);

    idle(); mtc0 = 1; mfc0 = 1; addr = 5'd8; wdata = 32'hDEAD_BEEF; #1;
    check("same_cycle_old", rdata, 32'h0000_1003);
    step(); idle();
    rd(5'd8, d); check("same_cycle_new", d, 32'hDEAD_BEEF);
    step();

    wr(5'd11, 32'h0);
    wr(5'd9, 32'hFFFF_FFFE);
    cnt_at_ti = -1;
    for (int i = 0; i < 12 && cnt_at_ti < 0; i++) begin
      rd(5'd9, d);
      if (timer_int) cnt_at_ti = int'(d);
      step();
    end
    check("wrap_ti_count", 32'(cnt_at_ti), 32'd0);

    idle(); #2; rst = 0; #1;
    check("arst_timer_int", {31'b0, timer_int}, 32'd0);
    check("arst_status", status, 32'h0);
    check("arst_epc", epc_out, 32'h0);
    rd(5'd9, d); check("arst_count", d, 32'h0);
    repeat (2) step();
    idle(); rst = 1;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
